armcpu: RTL and testbench

ARMCPU -- requirements
Module: armcpu

---
 rtl/armcpu_pkg.sv | 61 ++++++
 rtl/armcpu_uart_tx.sv | 67 ++++++
 rtl/armcpu.sv | 234 +++++++++++++++++++++++
 tb/tb_armcpu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/armcpu_pkg.sv
// Shared definitions for the armcpu boot-copy block: FSM state encodings,
// flash control bit positions, UART boot byte, VGA timing and the 7-segment
// glyph table (segment order a..g, active-high).
package armcpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FRD_LO = 3'd1,
        FRD_HI = 3'd2,
        SWR    = 3'd3,
        SREL   = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam int unsigned IDX_W  = 22;
    localparam int unsigned WAIT_W = 16;

    // flash_ctl = {byte_n, ce_n, oe_n, we_n, rp_n, vpen, 2'b00}
    localparam int unsigned FC_BYTE_N = 7;
    localparam int unsigned FC_CE_N   = 6;
    localparam int unsigned FC_OE_N   = 5;
    localparam int unsigned FC_WE_N   = 4;
    localparam int unsigned FC_RP_N   = 3;
    localparam int unsigned FC_VPEN   = 2;

    localparam logic [7:0] UART_BOOT_BYTE = 8'h4B;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] VS_START = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;

    // Hex digit to segments; index 0 of the result is segment a.
    function automatic logic [0:6] seg_glyph(input logic [3:0] v);
        logic [0:6] g;
        case (v)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/armcpu_uart_tx.sv
// 8N1 UART transmitter, LSB first, idle high.
// Ports: clk_i, rst_ni (async active-low), start_i (1-cycle request, ignored
// while busy), data_i (byte to send), txd_o (serial line).
module armcpu_uart_tx #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       txd_o
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);

    logic             busy_q, busy_d;
    logic             txd_q, txd_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bits_q, bits_d;
    logic [CNT_W-1:0] baud_q, baud_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
            shift_q <= '1;
            bits_q  <= '0;
            baud_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            txd_q   <= txd_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            baud_q  <= baud_d;
        end
    end

    // Shift register holds data bits then the stop bit; the start bit is driven on accept.
    always_comb begin
        busy_d  = busy_q;
        txd_d   = txd_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        baud_d  = baud_q;
        if (!busy_q) begin
            if (start_i) begin
                busy_d  = 1'b1;
                txd_d   = 1'b0;
                shift_d = {1'b1, data_i};
                bits_d  = 4'd9;
                baud_d  = BAUD_RELOAD;
            end
        end else if (baud_q != '0) begin
            baud_d = baud_q - CNT_W'(1);
        end else if (bits_q != '0) begin
            txd_d   = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bits_d  = bits_q - 4'd1;
            baud_d  = BAUD_RELOAD;
        end else begin
            busy_d = 1'b0;
        end
    end

    assign txd_o = txd_q;

endmodule

// File: rtl/armcpu.sv
// Boot-copy block: copies BOOT_WORDS 32-bit words from 16-bit flash into
// baseram, optionally single-stepped by clk_manual, reports progress on
// led/7-segment displays and sends 0x4B over UART when finished.
// Optional VGA timing generator is built only with macro ARMCPU_VGA_EN.
// Ports: clk50M/rst_key (clock, async active-low reset), clk_manual/params
// (step control), segdisp0/1 and led (status), baseram_*/extram_* (SRAM),
// flash_* (flash), com_TxD/com_RxD (UART), vga_* (video), kbd_* and eth_*
// (held idle / ignored).
module armcpu import armcpu_pkg::*; #(
    parameter int unsigned BOOT_WORDS = 1024,
    parameter int unsigned FLASH_WAIT = 4,
    parameter int unsigned BAUD_DIV   = 434
) (
    input  logic        clk50M,
    input  logic        rst_key,
    input  logic        clk_manual,
    input  logic [31:0] params,
    output logic [0:6]  segdisp0,
    output logic [0:6]  segdisp1,
    output logic [15:0] led,
    output logic [19:0] baseram_addr,
    inout  wire  [31:0] baseram_data,
    output logic        baseram_ce,
    output logic        baseram_oe,
    output logic        baseram_we,
    output logic [19:0] extram_addr,
    inout  wire  [31:0] extram_data,
    output logic        extram_ce,
    output logic        extram_oe,
    output logic        extram_we,
    output logic        com_TxD,
    input  logic        com_RxD,
    output logic [22:0] flash_addr,
    inout  wire  [15:0] flash_data,
    output logic [7:0]  flash_ctl,
    output logic [8:0]  vga_color_out,
    output logic        vga_hsync,
    output logic        vga_vsync,
    input  logic        kbd_enb_hi,
    input  logic        kbd_enb_lo,
    input  logic [3:0]  kbd_data,
    inout  wire  [15:0] eth_data,
    output logic        eth_cs,
    output logic        eth_cmd,
    output logic        eth_ior,
    output logic        eth_iow,
    output logic        eth_reset,
    input  logic        eth_int
);
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(FLASH_WAIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(BOOT_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        man_sync_q;
    logic              man_prev_q;
    logic [1:0]        rst_sync_q;
    logic              step;
    logic              tx_start;
    logic              in_frd;
    logic              ram_drv;
    logic              ram_wr;

    // Step-button synchronizer with rising-edge detect; reset synchronizer for eth_reset.
    always_ff @(posedge clk50M or negedge rst_key) begin
        if (!rst_key) begin
            man_sync_q <= '0;
            man_prev_q <= 1'b0;
            rst_sync_q <= '0;
        end else begin
            man_sync_q <= {man_sync_q[0], clk_manual};
            man_prev_q <= man_sync_q[1];
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign step      = params[0] | (man_sync_q[1] & ~man_prev_q);
    assign eth_reset = rst_sync_q[1];

    // FSM state and datapath registers.
    always_ff @(posedge clk50M or negedge rst_key) begin
        if (!rst_key) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic; every transition and wait decrement is qualified by step.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        word_d   = word_q;
        tx_start = 1'b0;
        if (step) begin
            case (state_q)
                IDLE: begin
                    state_d = FRD_LO;
                    idx_d   = '0;
                    wait_d  = WAIT_RELOAD;
                end
                FRD_LO: begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - WAIT_W'(1);
                    end else begin
                        word_d[15:0] = flash_data;
                        wait_d       = WAIT_RELOAD;
                        state_d      = FRD_HI;
                    end
                end
                FRD_HI: begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - WAIT_W'(1);
                    end else begin
                        word_d[31:16] = flash_data;
                        state_d       = SWR;
                    end
                end
                SWR:  state_d = SREL;
                SREL: begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d  = DONE;
                        tx_start = 1'b1;
                    end else begin
                        state_d = FRD_LO;
                        wait_d  = WAIT_RELOAD;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Bus strobes decode directly from the state register so reset releases them at once.
    assign in_frd  = (state_q == FRD_LO) || (state_q == FRD_HI);
    assign ram_wr  = (state_q == SWR);
    assign ram_drv = (state_q == SWR) || (state_q == SREL);

    assign flash_addr = {idx_q, (state_q == FRD_HI)};
    assign flash_data = 16'hzzzz;

    always_comb begin
        flash_ctl            = '0;
        flash_ctl[FC_BYTE_N] = 1'b1;
        flash_ctl[FC_CE_N]   = ~in_frd;
        flash_ctl[FC_OE_N]   = ~in_frd;
        flash_ctl[FC_WE_N]   = 1'b1;
        flash_ctl[FC_RP_N]   = 1'b1;
        flash_ctl[FC_VPEN]   = 1'b1;
    end

    assign baseram_addr = idx_q[19:0];
    assign baseram_data = ram_drv ? word_q : 32'hzzzz_zzzz;
    assign baseram_ce   = ~ram_wr;
    assign baseram_we   = ~ram_wr;
    assign baseram_oe   = 1'b1;

    assign extram_addr = '0;
    assign extram_data = 32'hzzzz_zzzz;
    assign extram_ce   = 1'b1;
    assign extram_oe   = 1'b1;
    assign extram_we   = 1'b1;

    assign eth_data = 16'hzzzz;
    assign eth_cs   = 1'b1;
    assign eth_cmd  = 1'b0;
    assign eth_ior  = 1'b1;
    assign eth_iow  = 1'b1;

    assign led      = {(state_q == DONE), 3'(state_q), idx_q[11:0]};
    assign segdisp0 = seg_glyph(idx_q[3:0]);
    assign segdisp1 = seg_glyph({1'b0, 3'(state_q)});

    armcpu_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk_i   (clk50M),
        .rst_ni  (rst_key),
        .start_i (tx_start),
        .data_i  (UART_BOOT_BYTE),
        .txd_o   (com_TxD)
    );

`ifdef ARMCPU_VGA_EN
    logic       pix_q;
    logic [9:0] h_q;
    logic [9:0] v_q;

    // Pixel counters advance on every second clk50M cycle.
    always_ff @(posedge clk50M or negedge rst_key) begin
        if (!rst_key) begin
            pix_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            pix_q <= ~pix_q;
            if (pix_q) begin
                if (h_q == H_TOTAL - 10'd1) begin
                    h_q <= '0;
                    v_q <= (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
                end else begin
                    h_q <= h_q + 10'd1;
                end
            end
        end
    end

    assign vga_hsync     = ~((h_q >= HS_START) && (h_q <= HS_END));
    assign vga_vsync     = ~((v_q >= VS_START) && (v_q <= VS_END));
    assign vga_color_out = ((h_q < H_ACTIVE) && (v_q < V_ACTIVE) && (state_q == DONE))
                           ? 9'h1FF : 9'h000;
`else
    assign vga_hsync     = 1'b1;
    assign vga_vsync     = 1'b1;
    assign vga_color_out = '0;
`endif

    // Inputs and buses this block deliberately ignores.
    logic unused_ok;
    assign unused_ok = ^{params[31:1], kbd_enb_hi, kbd_enb_lo, kbd_data, com_RxD,
                         eth_int, eth_data, extram_data};

endmodule

// File: tb/tb_armcpu.sv
// Scoreboard bench for armcpu: expected baseram writes and UART bytes are queued
// by the stimulus process and consumed by independent monitors.
module tb_armcpu;
    localparam int unsigned BW = 4;
    localparam int unsigned FW = 2;
    localparam int unsigned BD = 434;

    logic        clk50M = 1'b0;
    logic        rst_key;
    logic        clk_manual;
    logic [31:0] params;
    logic        com_RxD;
    logic        kbd_enb_hi, kbd_enb_lo;
    logic [3:0]  kbd_data;
    logic        eth_int;

    logic [0:6]  segdisp0, segdisp1;
    logic [15:0] led;
    logic [19:0] baseram_addr, extram_addr;
    wire  [31:0] baseram_data, extram_data;
    logic        baseram_ce, baseram_oe, baseram_we;
    logic        extram_ce, extram_oe, extram_we;
    logic        com_TxD;
    logic [22:0] flash_addr;
    wire  [15:0] flash_data;
    logic [7:0]  flash_ctl;
    logic [8:0]  vga_color_out;
    logic        vga_hsync, vga_vsync;
    wire  [15:0] eth_data;
    logic        eth_cs, eth_cmd, eth_ior, eth_iow, eth_reset;

    int vectors = 0;
    int errors  = 0;
    int uart_frames = 0;

    logic [19:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [7:0]  uq[$];

    always #10 clk50M = ~clk50M;

    // Flash model returns the low 16 address bits; baseram is pulled high when released.
    assign flash_data = flash_addr[15:0];
    for (genvar i = 0; i < 32; i++) begin : g_pu
        pullup (baseram_data[i]);
    end

    armcpu #(.BOOT_WORDS(BW), .FLASH_WAIT(FW), .BAUD_DIV(BD)) dut (
        .clk50M(clk50M), .rst_key(rst_key), .clk_manual(clk_manual), .params(params),
        .segdisp0(segdisp0), .segdisp1(segdisp1), .led(led),
        .baseram_addr(baseram_addr), .baseram_data(baseram_data),
        .baseram_ce(baseram_ce), .baseram_oe(baseram_oe), .baseram_we(baseram_we),
        .extram_addr(extram_addr), .extram_data(extram_data),
        .extram_ce(extram_ce), .extram_oe(extram_oe), .extram_we(extram_we),
        .com_TxD(com_TxD), .com_RxD(com_RxD),
        .flash_addr(flash_addr), .flash_data(flash_data), .flash_ctl(flash_ctl),
        .vga_color_out(vga_color_out), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .kbd_enb_hi(kbd_enb_hi), .kbd_enb_lo(kbd_enb_lo), .kbd_data(kbd_data),
        .eth_data(eth_data), .eth_cs(eth_cs), .eth_cmd(eth_cmd), .eth_ior(eth_ior),
        .eth_iow(eth_iow), .eth_reset(eth_reset), .eth_int(eth_int)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Baseram write monitor: one queued write per cycle with ce=0, we=0.
    always @(negedge clk50M) begin
        if (rst_key && !baseram_ce && !baseram_we) begin
            if (wq_addr.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         baseram_addr, baseram_data);
            end else begin
                chk("write_addr", 64'(baseram_addr), 64'(wq_addr.pop_front()));
                chk("write_data", 64'(baseram_data), 64'(wq_data.pop_front()));
                chk("write_oe", 64'(baseram_oe), 64'd1);
            end
        end
    end

    // UART monitor: sample each bit in its centre.
    initial begin
        logic [7:0] rx;
        logic       sb;
        forever begin
            @(negedge clk50M);
            if (rst_key && com_TxD == 1'b0) begin
                repeat (BD / 2) @(negedge clk50M);
                chk("uart_start", 64'(com_TxD), 64'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (BD) @(negedge clk50M);
                    rx[b] = com_TxD;
                end
                repeat (BD) @(negedge clk50M);
                sb = com_TxD;
                chk("uart_stop", 64'(sb), 64'd1);
                if (uq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_uart: got %0h expected none", rx);
                end else begin
                    chk("uart_byte", 64'(rx), 64'(uq.pop_front()));
                end
                uart_frames++;
                repeat (BD) @(negedge clk50M);
            end
        end
    end

    initial begin
        int n;
        rst_key = 1'b0; clk_manual = 1'b0; params = '0; com_RxD = 1'b1;
        kbd_enb_hi = 1'b0; kbd_enb_lo = 1'b0; kbd_data = '0; eth_int = 1'b0;
        for (int k = 0; k < int'(BW); k++) begin
            wq_addr.push_back(20'(k));
            wq_data.push_back({16'(2 * k + 1), 16'(2 * k)});
        end
        uq.push_back(8'h4B);

        // Reset state.
        #100;
        chk("rst_base_strobes", 64'({baseram_ce, baseram_oe, baseram_we}), 64'b111);
        chk("rst_base_data_z", 64'(baseram_data), 64'hFFFF_FFFF);
        chk("rst_ext", 64'({extram_ce, extram_oe, extram_we, extram_addr}), {41'd0, 3'b111, 20'd0});
        chk("rst_flash_ctl", 64'(flash_ctl), 64'hFC);
        chk("rst_txd", 64'(com_TxD), 64'd1);
        chk("rst_led", 64'(led), 64'd0);
        chk("rst_seg", 64'({segdisp0, segdisp1}), 64'(14'b1111110_1111110));
        chk("rst_eth", 64'({eth_cs, eth_cmd, eth_ior, eth_iow, eth_reset}), 64'b10110);
        chk("rst_vga", 64'({vga_hsync, vga_vsync, vga_color_out}), 64'(11'b11_000000000));

        // Single-step with no button edges: remain in IDLE.
        @(negedge clk50M); rst_key = 1'b1;
        repeat (10) @(negedge clk50M);
        chk("step_idle_led", 64'(led), 64'd0);
        chk("eth_reset_rel", 64'(eth_reset), 64'd1);

        // Three button pulses: IDLE -> FRD_LO -> (wait) -> FRD_HI.
        repeat (3) begin
            clk_manual = 1'b1; repeat (4) @(negedge clk50M);
            clk_manual = 1'b0; repeat (4) @(negedge clk50M);
        end
        repeat (4) @(negedge clk50M);
        chk("step3_led", 64'(led), 64'h2000);
        chk("step3_seg1", 64'(segdisp1), 64'(7'b1101101));
        chk("step3_faddr", 64'(flash_addr), 64'd1);
        chk("step3_fctl", 64'(flash_ctl), 64'h9C);

        // Free-run to completion.
        params = 32'd1;
        n = 0;
        while (!led[15] && n < 1000) begin @(negedge clk50M); n++; end
        chk("done_reached", 64'(led[15]), 64'd1);
        chk("done_led", 64'(led), 64'hD004);
        chk("done_seg", 64'({segdisp0, segdisp1}), 64'(14'b0110011_1011011));
        chk("done_bus_idle", 64'({baseram_we, baseram_ce, baseram_data}), {30'd0, 2'b11, 32'hFFFF_FFFF});
        chk("done_fctl", 64'(flash_ctl), 64'hFC);
        chk("writes_drained", 64'(wq_addr.size()), 64'd0);
`ifndef ARMCPU_VGA_EN
        chk("novga_color", 64'({vga_hsync, vga_vsync, vga_color_out}), 64'(11'b11_000000000));
`endif

        n = 0;
        while (uart_frames < 1 && n < 8000) begin @(negedge clk50M); n++; end
        chk("uart_frames", 64'(uart_frames), 64'd1);

`ifdef ARMCPU_VGA_EN
        begin
            int lo, per;
            n = 0;
            while (vga_hsync && n < 2000) begin @(negedge clk50M); n++; end
            lo = 0;
            while (!vga_hsync && lo < 2000) begin @(negedge clk50M); lo++; end
            per = lo;
            while (vga_hsync && per < 4000) begin @(negedge clk50M); per++; end
            chk("vga_hs_low", 64'(lo), 64'd192);
            chk("vga_hs_period", 64'(per), 64'd1600);
        end
`endif

        // Mid-copy reset during SWR.
        @(negedge clk50M); rst_key = 1'b0;
        repeat (3) @(negedge clk50M);
        wq_addr.push_back(20'd0);
        wq_data.push_back(32'h0001_0000);
        rst_key = 1'b1;
        n = 0;
        while (baseram_we && n < 100) begin @(negedge clk50M); n++; end
        chk("swr_reached", 64'(baseram_we), 64'd0);
        #2 rst_key = 1'b0;
        #1;
        chk("abort_strobes", 64'({baseram_ce, baseram_we}), 64'b11);
        chk("abort_data_z", 64'(baseram_data), 64'hFFFF_FFFF);
        chk("abort_led", 64'(led), 64'd0);
        chk("abort_txd", 64'(com_TxD), 64'd1);
        repeat (5) @(negedge clk50M);
        chk("abort_writes", 64'(wq_addr.size()), 64'd0);
        chk("uart_once", 64'(uart_frames), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
